tristate_buffer: RTL and testbench
==================================

// Module: tristate_buffer
// PURPOSE
//  Open-drain pad helper for one I2C line (SCL or SDA).
//  - Drive side: the output value is fixed LOW; only the output enable (oen) switches, i.e. "drive 0" or "release".
//  - Receive side: synchronises the external line, samples it at a prescaled rate, majority-filters it, and supplies stable and one-cycle-delayed copies to the bit controller.
// PARAMETERS
//  CNT_W      16  width of clk_cnt prescale input
//  FILT_W     14  width of filter_cnt (= CNT_W-2)
//  SYNC_STG    2  input synchroniser depth
// PORTS
//  clk             in   1   single system clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  nReset          in   1   synchronous active-low clear; same effect as rst, applied on clk edge
//  ena             in   1   core enable; 0 holds prescaler at 0
//  clk_cnt         in   16  prescale value; filter period = clk_cnt>>2
//  signal          in   1   1 = pull line LOW, 0 = release line
//  in              in   1   external line level (pad input)
//  out             out  1   pad output value, constant 0
//  oen             out  1   pad output enable, active-low (0 = drive out, 1 = high-Z)
//  doen            out  1   oen delayed one clk
//  dSignal         out  1   sSignal delayed one clk
//  sSignal         out  1   filtered, stable line level
//  filter_cnt      out  14  prescaler count (debug)
//  sample_trigger  out  1   one-cycle sample strobe (debug)
// BEHAVIOUR
//  Reset (rst=1 async, or nReset=0 at clk edge):
//    oen=1, doen=1, sync=2'b11, filt=3'b111, sSignal=1, dSignal=1, filter_cnt=0.
//  Drive path:
//    oen <= ~signal each clk, giving 1 clk latency; doen <= oen.
//    out is tied to 0. ena does not gate the drive path.
//  Synchroniser:
//    sync <= {sync[0], in} every clk; sync[1] is the synchronised level.
//  Prescaler:
//    If !ena, filter_cnt <= 0.
//    Else, if filter_cnt == 0, filter_cnt <= clk_cnt[15:2].
//    Else, filter_cnt <= filter_cnt - 1.
//    sample_trigger = ena & (filter_cnt == 0), combinational.
//    Strobe period = clk_cnt[15:2] + 1 clks.
//    clk_cnt < 4 gives a reload of 0, i.e. a strobe every clk.
//    A clk_cnt change takes effect at the next reload; the current countdown is not disturbed.
//  Filter:
//    On sample_trigger, filt <= {filt[1:0], sync[1]}.
//    sSignal <= majority(filt) = (f0&f1)|(f0&f2)|(f1&f2), every clk.
//    dSignal <= sSignal.
//    When ena=0, filt is frozen, so sSignal and dSignal hold.
//  Latency:
//    in edge -> sync[1] in 2 clks.
//    The majority result changes after 2 matching samples, then +1 clk to sSignal.
//  Glitch rule: a level present for only 1 sample is rejected.
//  Simultaneous events:
//    rst dominates nReset, which dominates ena.
//    A reset mid-count restarts the prescaler at 0, so a strobe follows on the first enabled cycle.
// CONFIGURATION
//  TRISTATE_BUFFER_DEBUG_EN
//    Defined: filter_cnt and sample_trigger reflect internal state.
//    Undefined: both ports exist but are tied to 0; all functional behaviour is unchanged.
// TESTING (bench defines TRISTATE_BUFFER_DEBUG_EN; clk period 20)
//  1. rst=1 and nReset=0 held, then released, ena=0
//     -> oen=doen=sSignal=dSignal=1, out=0, filter_cnt=0.
//  2. ena=1, clk_cnt=4
//     -> filter_cnt alternates 1,0; sample_trigger high every 2nd clk.
//  3. in held low >= 3 strobes after reset
//     -> sSignal falls; dSignal falls exactly 1 clk later.
//  4. in=1 pulse lasting 1 strobe window
//     -> sSignal stays 0.
//     in=1 held for 2 strobes
//     -> sSignal rises.
//  5. signal=1 for 1 clk
//     -> oen=0 for 1 clk after the next edge; doen=0 one clk later; out stays 0.
//  6. clk_cnt=15 mid-count
//     -> next reload value 3 (period 4).
//     ena=0
//     -> filter_cnt=0, sample_trigger=0, sSignal holds.
//     ena=1
//     -> strobe on the first enabled cycle.

Source files
------------

// File: rtl/tristate_buffer.sv
// Open-drain pad helper for one I2C line (SCL or SDA).
// Drive side only ever pulls the line low: out is tied to 0 and the
// registered, inverted request becomes the active-low output enable.
// Receive side synchronises the pad, samples it on a prescaled strobe,
// majority-filters three samples and provides stable and delayed levels.
// There is no handshake and no FSM: every output is a plain registered
// level, except sample_trigger, which is a combinational strobe.
// Optional macro TRISTATE_BUFFER_DEBUG_EN: when defined, filter_cnt and
// sample_trigger show the prescaler; otherwise both ports are tied to 0.
module tristate_buffer #(
  parameter int CNT_W    = 16,
  parameter int FILT_W   = 14,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nReset,
  input  logic              ena,
  input  logic [CNT_W-1:0]  clk_cnt,
  input  logic              signal,
  input  logic              in,
  output logic              out,
  output logic              oen,
  output logic              doen,
  output logic              dSignal,
  output logic              sSignal,
  output logic [FILT_W-1:0] filter_cnt,
  output logic              sample_trigger
);

  logic                oen_q, oen_d;
  logic                doen_q, doen_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]          filt_q, filt_d;
  logic                ssig_q, ssig_d;
  logic                dsig_q, dsig_d;
  logic                trig;
  logic                synced;
  logic                majority;

  // The two low prescale bits only set the sub-filter-period resolution
  // and are deliberately ignored.
  logic unused_clk_cnt_lsbs;
  assign unused_clk_cnt_lsbs = ^clk_cnt[1:0];

  assign synced   = sync_q[SYNC_STG-1];
  assign trig     = ena & (cnt_q == '0);
  assign majority = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) |
                    (filt_q[1] & filt_q[2]);

  // Drive path: request is registered and inverted, ena does not gate it.
  always_comb begin
    oen_d  = ~signal;
    doen_d = oen_q;
    if (!nReset) begin
      oen_d  = 1'b1;
      doen_d = 1'b1;
    end
  end

  // Input synchroniser: shift the pad level in every clock, idle high.
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], in};
    if (!nReset) begin
      sync_d = '1;
    end
  end

  // Prescaler: reload from clk_cnt>>2 at zero, so a new clk_cnt only
  // matters at the next reload; disabled core parks the count at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!nReset || !ena) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = clk_cnt[CNT_W-1:2];
    end else begin
      cnt_d = cnt_q - FILT_W'(1);
    end
  end

  // Filter: shift a sample in on each strobe, vote every clock, then delay.
  always_comb begin
    filt_d = filt_q;
    ssig_d = majority;
    dsig_d = ssig_q;
    if (trig) begin
      filt_d = {filt_q[1:0], synced};
    end
    if (!nReset) begin
      filt_d = 3'b111;
      ssig_d = 1'b1;
      dsig_d = 1'b1;
    end
  end

  // State registers; async rst wins over everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oen_q  <= 1'b1;
      doen_q <= 1'b1;
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 3'b111;
      ssig_q <= 1'b1;
      dsig_q <= 1'b1;
    end else begin
      oen_q  <= oen_d;
      doen_q <= doen_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      ssig_q <= ssig_d;
      dsig_q <= dsig_d;
    end
  end

  assign out     = 1'b0;
  assign oen     = oen_q;
  assign doen    = doen_q;
  assign sSignal = ssig_q;
  assign dSignal = dsig_q;

`ifdef TRISTATE_BUFFER_DEBUG_EN
  assign filter_cnt     = cnt_q;
  assign sample_trigger = trig;
`else
  assign filter_cnt     = '0;
  assign sample_trigger = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_buffer.sv
// Bench for tristate_buffer: cycle model of the pad helper plus directed
// vectors with hand-computed expectations.
`define TRISTATE_BUFFER_DEBUG_EN
module tb_tristate_buffer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nReset = 1'b0;
  logic        ena = 1'b0;
  logic [15:0] clk_cnt = 16'd0;
  logic        signal = 1'b0;
  logic        in = 1'b1;
  logic        out, oen, doen, dSignal, sSignal, sample_trigger;
  logic [13:0] filter_cnt;

  always #10 clk = ~clk;

  tristate_buffer dut (
    .clk(clk), .rst(rst), .nReset(nReset), .ena(ena), .clk_cnt(clk_cnt),
    .signal(signal), .in(in), .out(out), .oen(oen), .doen(doen),
    .dSignal(dSignal), .sSignal(sSignal), .filter_cnt(filter_cnt),
    .sample_trigger(sample_trigger)
  );

  int total = 0;
  int bad   = 0;
  bit dbg_known = 1'b0;
  bit dbg_live  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Debug ports carry the prescaler only when the build exposes it.
  function automatic int dbg_exp(input int v);
    return dbg_live ? v : 0;
  endfunction

  // ---------------- behavioural model ----------------
  // Line history, last three strobe samples and a countdown to the next
  // strobe; the filtered level is "at least two of three samples high".
  bit m_oen, m_doen, m_s, m_d;
  int m_cnt;
  bit in_hist[$];
  bit samp[$];
  bit strobe_now, synced_now;
  int ones;

  always @(posedge clk or posedge rst) begin
    if (rst || !nReset) begin
      m_oen = 1'b1; m_doen = 1'b1; m_s = 1'b1; m_d = 1'b1; m_cnt = 0;
      in_hist = {1'b1, 1'b1};
      samp = {1'b1, 1'b1, 1'b1};
    end else begin
      strobe_now = ena && (m_cnt == 0);
      synced_now = in_hist[0];
      ones = 0;
      foreach (samp[i]) ones += int'(samp[i]);
      m_d = m_s;
      m_s = (ones >= 2);
      m_doen = m_oen;
      m_oen = !signal;
      in_hist.push_back(in);
      void'(in_hist.pop_front());
      if (strobe_now) begin
        samp.push_back(synced_now);
        void'(samp.pop_front());
      end
      if (!ena) m_cnt = 0;
      else if (m_cnt == 0) m_cnt = int'(clk_cnt[15:2]);
      else m_cnt = m_cnt - 1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("oen", int'(oen), int'(m_oen));
    chk("doen", int'(doen), int'(m_doen));
    chk("out", int'(out), 0);
    chk("sSignal", int'(sSignal), int'(m_s));
    chk("dSignal", int'(dSignal), int'(m_d));
    if (dbg_known) begin
      chk("filter_cnt", int'(filter_cnt), dbg_exp(m_cnt));
      chk("sample_trigger", int'(sample_trigger), dbg_exp(int'(ena && m_cnt == 0)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int exp_cnt[7]  = '{1, 0, 3, 2, 1, 0, 3};
  int exp_trig[7] = '{0, 1, 0, 0, 0, 1, 0};

  initial begin
    int k;
    bit found;
    bit d_at_fall;

    // 1. reset, then release rst while nReset still clears
    repeat (3) step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rst_oen", int'(oen), 1);
    chk("rst_doen", int'(doen), 1);
    chk("rst_ssig", int'(sSignal), 1);
    chk("rst_dsig", int'(dSignal), 1);
    chk("rst_out", int'(out), 0);
    chk("rst_fcnt", int'(filter_cnt), 0);
    step();
    nReset = 1'b1;
    repeat (2) step();

    // 2. ena=1, clk_cnt=4: counts 0,1,0,1 with strobe on the zeros
    clk_cnt = 16'd4;
    ena = 1'b1;
    @(negedge clk);
    if (filter_cnt == 14'd0 && sample_trigger == 1'b1) begin
      dbg_live = 1'b1;
      chk("dbg_probe", 1, 1);
    end else begin
      dbg_live = 1'b0;
      chk("dbg_probe", int'(filter_cnt) + int'(sample_trigger), 0);
    end
    dbg_known = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("pre_fcnt", int'(filter_cnt), dbg_exp(i % 2));
      chk("pre_trig", int'(sample_trigger), dbg_exp(1 - (i % 2)));
    end

    // 3. line goes low in cycle 4; sSignal falls at cycle 10
    step();
    in = 1'b0;
    k = 0;
    found = 1'b0;
    d_at_fall = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (sSignal == 1'b0) begin
        k = i;
        found = 1'b1;
        d_at_fall = dSignal;
      end
    end
    chk("ssig_fall_lat", k, 7);
    chk("dsig_at_fall", int'(d_at_fall), 1);
    @(negedge clk);
    chk("dsig_follow", int'(dSignal), 0);

    // 4. one-strobe glitch rejected, two-strobe level accepted
    step();
    in = 1'b1;
    repeat (2) step();
    in = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("glitch_reject", int'(sSignal), 0);
    step();
    in = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("level_accept", int'(sSignal), 1);

    // 5. one-clock drive request
    step();
    signal = 1'b1;
    @(negedge clk);
    chk("oen_before", int'(oen), 1);
    step();
    signal = 1'b0;
    @(negedge clk);
    chk("oen_drive", int'(oen), 0);
    chk("doen_lag", int'(doen), 1);
    chk("out_zero", int'(out), 0);
    step();
    @(negedge clk);
    chk("oen_release", int'(oen), 1);
    chk("doen_drive", int'(doen), 0);
    step();
    @(negedge clk);
    chk("doen_release", int'(doen), 1);

    // 6. prescale change mid-count takes effect at the next reload
    step();
    clk_cnt = 16'd8;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_cnt == 2) found = 1'b1;
    end
    chk("cnt2_reached", int'(found), 1);
    clk_cnt = 16'd15;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("reload_fcnt", int'(filter_cnt), dbg_exp(exp_cnt[i]));
      chk("reload_trig", int'(sample_trigger), dbg_exp(exp_trig[i]));
    end

    // disabled core: prescaler parked, filter frozen despite line low
    step();
    ena = 1'b0;
    in = 1'b0;
    @(negedge clk);
    chk("dis_fcnt", int'(filter_cnt), 0);
    chk("dis_trig", int'(sample_trigger), 0);
    repeat (8) step();
    @(negedge clk);
    chk("dis_ssig_hold", int'(sSignal), 1);
    chk("dis_dsig_hold", int'(dSignal), 1);
    step();
    ena = 1'b1;
    @(negedge clk);
    chk("reen_trig", int'(sample_trigger), dbg_exp(1));
    chk("reen_fcnt", int'(filter_cnt), 0);

    // synchronous clear mid-count, then strobe on first enabled cycle
    repeat (3) step();
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    @(negedge clk);
    chk("nrst_fcnt", int'(filter_cnt), 0);
    chk("nrst_trig", int'(sample_trigger), dbg_exp(1));
    chk("nrst_ssig", int'(sSignal), 1);

    // asynchronous reset pulse between edges
    repeat (5) step();
    #4 rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    chk("arst_oen", int'(oen), 1);
    chk("arst_ssig", int'(sSignal), 1);
    chk("arst_fcnt", int'(filter_cnt), 0);
    repeat (12) step();

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound.
  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
